// File: rtl/controle_multiciclo.sv
// Multicycle Moore control unit for the RV32I-subset datapath: fetch, field latch,
// per-class strobe sequencing over 3-5 cycles, retire counter and sticky illegal trap.
module controle_multiciclo #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    output logic [3:0]         ALUControl,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               Jump,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [3:0]         state,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ALU_WB   = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_e             state_q, state_d;
    logic [6:0]         opcode_q, opcode_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [6:0]         funct7_q, funct7_d;
    logic [COUNT_W-1:0] retired_q, retired_d;

    logic [3:0] base_alu, exec_alu;
    logic       base_legal, is_shift, r_legal, i_legal;

    // Decode works only from the latched fields, never from the live instruction bus.
    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        base_alu   = ALU_ADD;
        base_legal = 1'b1;
        case (funct3_q)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            3'b111:  base_alu = ALU_AND;
            default: base_legal = 1'b0;
        endcase
        is_shift = (funct3_q == 3'b001) || (funct3_q == 3'b101);
        r_legal  = (base_legal && funct7_q == 7'b0000000)
                || (funct3_q == 3'b000 && funct7_q == 7'b0100000);
        i_legal  = base_legal && (!is_shift || funct7_q == 7'b0000000);
        exec_alu = base_alu;
        if (opcode_q == OP_R && funct7_q == 7'b0100000) begin
            exec_alu = ALU_SUB;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        retired_d = retired_q;
        if (enable) begin
            case (state_q)
                S_FETCH: begin
                    state_d  = S_DECODE;
                    opcode_d = opcode;
                    funct3_d = funct3;
                    funct7_d = funct7;
                end
                S_DECODE: begin
                    state_d = S_TRAP;
                    if (opcode_q == OP_R && r_legal)                  state_d = S_EXEC_R;
                    if (opcode_q == OP_I && i_legal)                  state_d = S_EXEC_I;
                    if (opcode_q == OP_LW && funct3_q == 3'b010)      state_d = S_MEM_ADDR;
                    if (opcode_q == OP_SW && funct3_q == 3'b010)      state_d = S_MEM_ADDR;
                    if (opcode_q == OP_BEQ && funct3_q == 3'b000)     state_d = S_BRANCH;
                    if (opcode_q == OP_JAL)                           state_d = S_JUMP;
                end
                S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
                S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_d = S_MEM_WB;
                S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + COUNT_W'(1);
                end
                default:    state_d = S_TRAP;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset here is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        ALUControl = ALU_AND;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        case (state_q)
            S_FETCH: IRWrite = 1'b1;
            S_EXEC_R, S_EXEC_I: begin
                ALUControl = exec_alu;
                ALUSrc     = (opcode_q == OP_I);
            end
            S_ALU_WB: begin
                ALUControl = exec_alu;
                ALUSrc     = (opcode_q == OP_I);
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUControl = ALU_ADD;
                ALUSrc     = 1'b1;
            end
            S_MEM_RD: begin
                ALUControl = ALU_ADD;
                ALUSrc     = 1'b1;
                MemRead    = 1'b1;
            end
            // MemRead stays up through write-back so the datapath read register survives the edge.
            S_MEM_WB: begin
                ALUControl = ALU_ADD;
                ALUSrc     = 1'b1;
                MemRead    = 1'b1;
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
            end
            S_MEM_WR: begin
                ALUControl = ALU_ADD;
                ALUSrc     = 1'b1;
                MemWrite   = 1'b1;
                PCWrite    = 1'b1;
            end
            S_BRANCH: begin
                ALUControl = ALU_SUB;
                Branch     = 1'b1;
                PCWrite    = 1'b1;
            end
            S_JUMP: begin
                Jump     = 1'b1;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
        if (!enable) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
        end
        if (reset) begin
            ALUControl = ALU_AND;
            ALUSrc     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            Branch     = 1'b0;
            Jump       = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = (state_q == S_TRAP);
    assign retired = retired_q;

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the RV32I-subset datapath (`parte_operativa`), which has a registered data-memory read and therefore cannot complete loads in one cycle. A Moore FSM fetches each instruction and latches its decode fields. It then sequences the datapath strobes (`ALUControl`, `ALUSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `Jump`) over 3–5 cycles, adds PC/IR write enables, and counts retired instructions. Unsupported encodings park the FSM in a sticky trap.

## Interface
- `COUNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run enable; 0 freezes the FSM.
- `opcode`  in  7  `Instr[6:0]` from datapath.
- `funct3`  in  3  `Instr[14:12]`.
- `funct7`  in  7  `Instr[31:25]`.
- `ALUControl`  out  4  datapath ALU op:
  - `0000` and, `0001` or, `0010` add, `0011` sll
  - `0100` xor, `0101` srl, `0110` sub, `0111` slt
- `ALUSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `Jump`  out  1 each  datapath controls.
- `IRWrite`  out  1  latch instruction fields this cycle.
- `PCWrite`  out  1  PC register update enable.
- `state`  out  4  current state encoding (debug).
- `illegal`  out  1  FSM is in TRAP.
- `retired`  out  `COUNT_W`  count of completed instructions.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9, ALU_WB=10, TRAP=11. Encodings 12–15 go to TRAP.
- **Field latch:** FETCH asserts `IRWrite`. On exit from FETCH, `opcode`/`funct3`/`funct7` are captured into internal registers. All later decode uses only the latched copies.
- **Paths** (each ends in FETCH):
  - R-type `0110011`: DECODE→EXEC_R→ALU_WB.
  - I-ALU `0010011`: DECODE→EXEC_I→ALU_WB.
  - LW (`0000011`, f3 `010`): DECODE→MEM_ADDR→MEM_RD→MEM_WB.
  - SW (`0100011`, f3 `010`): DECODE→MEM_ADDR→MEM_WR.
  - BEQ (`1100011`, f3 `000`): DECODE→BRANCH.
  - JAL (`1101111`): DECODE→JUMP.
  - Anything else: DECODE→TRAP.
- **R-type decode** (funct3/funct7):
  - `000`/`0000000` add, `000`/`0100000` sub
  - `111` and, `110` or, `100` xor, `010` slt (funct7 `0000000` for these four)
  - `001`/`0000000` sll, `101`/`0000000` srl
  - Anything else (sra, sltu, …) is illegal.
- **I-ALU decode:**
  - `000` add, `111` and, `110` or, `100` xor, `010` slt (funct7 ignored)
  - `001`/`0000000` sll, `101`/`0000000` srl
  - `011`, or shifts with other funct7, are illegal.
- **Outputs per state** (unlisted = 0):
  - FETCH: `IRWrite`.
  - EXEC_R: `ALUSrc`=0, decoded `ALUControl`.
  - EXEC_I: `ALUSrc`=1, decoded `ALUControl`.
  - ALU_WB: same ALU outputs as the EXEC state, plus `RegWrite`, `PCWrite`.
  - MEM_ADDR: `ALUSrc`, `ALUControl`=add.
  - MEM_RD: MEM_ADDR outputs plus `MemRead`.
  - MEM_WB: MEM_RD outputs plus `MemtoReg`, `RegWrite`, `PCWrite`. `MemRead` stays high so the datapath read register is not cleared before the write edge.
  - MEM_WR: MEM_ADDR outputs plus `MemWrite`, `PCWrite`.
  - BRANCH: `Branch`, `ALUControl`=sub, `ALUSrc`=0, `PCWrite`. The datapath mux picks the target or PC+4 from Zero.
  - JUMP: `Jump`, `RegWrite`, `PCWrite`.
  - TRAP: `illegal`=1, all strobes 0.
- **Retire:** `retired` increments by 1 on every edge that leaves ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP. It wraps modulo 2^`COUNT_W`.
- **TRAP** is absorbing; only `reset` exits it.
- **`enable`=0:** state, latched fields and `retired` hold. The strobes `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` and `MemRead` are forced 0. `ALUControl`, `ALUSrc`, `MemtoReg`, `Branch` and `Jump` keep their state values.

## Timing
- **Reset values:** `state`=FETCH, latched fields 0, `retired`=0, `illegal`=0.
- **During reset:** every strobe is gated to 0, including `IRWrite`; `ALUControl`=`0000`.
- **Asserting `reset` mid-instruction:** takes effect immediately (asynchronous); no partial `RegWrite`/`MemWrite` occurs after assertion. The first FETCH is the first cycle with `reset` low.
- **Output path:** outputs are a pure function of the state register, latched fields, `enable` and `reset`. There is no `opcode`/`funct*` → output combinational path.
- **Latency** (cycles per instruction, FETCH inclusive): R/I 4, LW 5, SW 4, BEQ 3, JAL 3. A frozen `enable`=0 cycle adds exactly 1.
- **Single-edge rule:** `PCWrite` is high in exactly one cycle per instruction, the last one. It coincides with that instruction's `RegWrite`/`MemWrite` edge.

## Test plan
- **ADDI `0x00500093`:** after reset release, `state` sequence is 0,1,3,10,0.
  - `IRWrite` high in cycle 0 only.
  - Cycles 2–3: `ALUSrc`=1, `ALUControl`=`0010`.
  - `RegWrite` and `PCWrite` high in cycle 3 only; `retired`=1 afterwards.
- **R-type decode:**
  - SUB `0x40208033` → EXEC_R with `ALUControl`=`0110`.
  - SLT `0x0020A033` → `0111`.
  - SRA `0x4020D033` → TRAP, `illegal`=1.
- **LW `0x00002203`:**
  - States 0,1,4,5,6.
  - `MemRead` high in cycles 3–4; `MemtoReg`+`RegWrite`+`PCWrite` in cycle 4.
  - `retired` increments once.
- **SW, BEQ, JAL in sequence:**
  - SW `0x00302023`: 4 cycles, `MemWrite` in cycle 3 only.
  - BEQ `0x00320463`: 3 cycles, `Branch`=1, `ALUControl`=`0110`.
  - JAL `0x008002EF`: 3 cycles, `Jump`+`RegWrite`+`PCWrite` in cycle 2.
  - `retired`=3 at the end.
- **Illegal `0x00000000`:** FSM enters TRAP on the third cycle, `illegal`=1. With valid instructions driven afterwards, it holds for 20 cycles with no strobes; `reset` then returns it to FETCH with `illegal`=0.
- **Stall and reset:**
  - `enable`=0 for 3 cycles in MEM_RD: `state` stays 5, `MemRead`=0, `retired` unchanged; the instruction completes normally after release.
  - `reset` asserted mid-cycle in MEM_WR: `MemWrite` drops immediately, `state`=0, `retired`=0.
